ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS-style pipeline, sitting between the ID stage (which supplies the registered ID/EX control and operands) and the MEM stage. It resolves data hazards by forwarding from the MEM/WB and WB results, performs the ALU operation, and registers the results into the EX/MEM pipeline register. Its EX/MEM outputs also feed back to the ID stage for load-use stall detection.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-number width

Ports:
Clk  in  1  pipeline clock, rising-edge active
Rst_n  in  1  asynchronous active-low reset
MEMRegWrite  in  1  MEM/WB stage will write a register
MEMData  in  DATA_W  MEM/WB result value
MEMRd  in  REG_AW  MEM/WB destination register
WBRegWrite  in  1  WB stage is writing a register
WBData  in  DATA_W  WB result value
WBRd  in  REG_AW  WB destination register
ALUSrc  in  1  1 = operand B from SignExtend, 0 = from forwarded DataB
ALUControl  in  3  ALU operation select
MemRead  in  1  instruction is a load
MemWrite  in  1  instruction is a store
RegWrite  in  1  instruction writes a register
DataA  in  DATA_W  register-file value of Rs
DataB  in  DATA_W  register-file value of Rt
SignExtend  in  DATA_W  sign-extended immediate
Rs  in  REG_AW  source register A number
Rt  in  REG_AW  source register B number
Rd  in  REG_AW  final destination register (ID has already applied the Rt/Rd choice)
EXRegWrite  out  1  registered RegWrite
EXMemRead  out  1  registered MemRead
EXMemWrite  out  1  registered MemWrite
EXRd  out  REG_AW  registered Rd
EXData  out  DATA_W  registered store data (forwarded operand B before the ALUSrc mux)
EXALUData  out  DATA_W  registered ALU result / memory address

Behaviour:
- Reset: while Rst_n=0, all outputs are 0, asynchronously; outputs stay 0 until the first rising Clk edge after release.
- Forwarding for A (same rule for B with Rt and DataB):
  - if MEMRegWrite=1, MEMRd!=0 and MEMRd==Rs, use MEMData;
  - else if WBRegWrite=1, WBRd!=0 and WBRd==Rs, use WBData;
  - else use DataA.
  - MEM has priority over WB when both match. Register 0 is never forwarded.
- Forwarding is purely combinational; no stall logic lives in this block (ID handles load-use stalls).
- OpB = SignExtend if ALUSrc=1, else forwarded B.
- ALUControl encoding:
  - 000 AND; 001 OR; 010 ADD; 011 XOR; 100 NOR; 101 SLTU (unsigned less-than, result 1 or 0); 110 SUB (A-B); 111 SLT (signed less-than, result 1 or 0).
  - ADD and SUB wrap modulo 2^DATA_W; no overflow flag or exception.
- Latency: one cycle. On each rising Clk edge, EXALUData <= ALU result, EXData <= forwarded B, and EXRegWrite/EXMemRead/EXMemWrite/EXRd <= RegWrite/MemRead/MemWrite/Rd.
- No enable or flush input: bubbles arrive from ID as all-zero control, and the stage propagates them unchanged.
- Rd=0 with RegWrite=1 is passed through unchanged; downstream stages ignore writes to register 0.

Test Plan:
- Reset: assert Rst_n=0 mid-run -> all outputs become 0 immediately; release, then DataA=5, DataB=3, ALUControl=010, RegWrite=1, Rd=4 -> after one edge EXALUData=8, EXRegWrite=1, EXRd=4.
- ALU sweep with A=0xF0F0F0F0, B=0x0FF00FF0: AND=0x00F000F0, OR=0xFFF0FFF0, XOR=0xFF00FF00, NOR=0x000F000F, SUB=0xE100E100; SLT(-1,1)=1; SLTU(0xFFFFFFFF,1)=0.
- Immediate path: ALUSrc=1, DataA=0x100, SignExtend=0xFFFFFFFC, ADD, MemWrite=1, DataB=0xAB -> EXALUData=0xFC, EXData=0xAB, EXMemWrite=1.
- Forwarding priority: Rs=Rt=7, MEMRegWrite=1, MEMRd=7, MEMData=10, WBRegWrite=1, WBRd=7, WBData=20, ADD -> EXALUData=20. With MEMRegWrite=0 -> 40. With both disabled, DataA=DataB=1 -> 2.
- Register-0 guard: Rs=0, MEMRd=0, MEMRegWrite=1, MEMData=99, DataA=0, DataB=0, OR -> EXALUData=0.
- Store-data forwarding: MemWrite=1, ALUSrc=1, Rt=3, MEMRd=3, MEMRegWrite=1, MEMData=0x55 -> EXData=0x55.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage pipeline: operand forwarding from MEM/WB and WB,
// the ALU, and the EX/MEM pipeline register feeding MEM and ID's hazard logic.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              MEMRegWrite,
    input  logic [DATA_W-1:0] MEMData,
    input  logic [REG_AW-1:0] MEMRd,
    input  logic              WBRegWrite,
    input  logic [DATA_W-1:0] WBData,
    input  logic [REG_AW-1:0] WBRd,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUControl,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] DataA,
    input  logic [DATA_W-1:0] DataB,
    input  logic [DATA_W-1:0] SignExtend,
    input  logic [REG_AW-1:0] Rs,
    input  logic [REG_AW-1:0] Rt,
    input  logic [REG_AW-1:0] Rd,
    output logic              EXRegWrite,
    output logic              EXMemRead,
    output logic              EXMemWrite,
    output logic [REG_AW-1:0] EXRd,
    output logic [DATA_W-1:0] EXData,
    output logic [DATA_W-1:0] EXALUData
);

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_NOR  = 3'b100,
        ALU_SLTU = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    alu_op_e           alu_op;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;

    // The younger MEM/WB result wins over WB; register 0 is hardwired and never forwarded.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_value
    );
        if (MEMRegWrite && (MEMRd != '0) && (MEMRd == src))
            return MEMData;
        else if (WBRegWrite && (WBRd != '0) && (WBRd == src))
            return WBData;
        else
            return rf_value;
    endfunction

    assign alu_op = alu_op_e'(ALUControl);
    assign fwd_a  = forward(Rs, DataA);
    assign fwd_b  = forward(Rt, DataB);
    assign op_b   = ALUSrc ? SignExtend : fwd_b;

    always_comb begin
        // NOTE: default assignment first so every path drives alu_result and no latch is inferred.
        alu_result = '0;
        case (alu_op)
            ALU_AND:  alu_result = fwd_a & op_b;
            ALU_OR:   alu_result = fwd_a | op_b;
            ALU_ADD:  alu_result = fwd_a + op_b;
            ALU_XOR:  alu_result = fwd_a ^ op_b;
            ALU_NOR:  alu_result = ~(fwd_a | op_b);
            ALU_SLTU: alu_result = DATA_W'(fwd_a < op_b);
            ALU_SUB:  alu_result = fwd_a - op_b;
            ALU_SLT:  alu_result = DATA_W'($signed(fwd_a) < $signed(op_b));
            default:  alu_result = '0;
        endcase
    end

    // Store data is the forwarded B operand, taken before the immediate mux.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            EXRegWrite <= 1'b0;
            EXMemRead  <= 1'b0;
            EXMemWrite <= 1'b0;
            EXRd       <= '0;
            EXData     <= '0;
            EXALUData  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all pipeline fields update together at the edge.
            EXRegWrite <= RegWrite;
            EXMemRead  <= MemRead;
            EXMemWrite <= MemWrite;
            EXRd       <= Rd;
            EXData     <= fwd_b;
            EXALUData  <= alu_result;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: reset, ALU sweep, immediate path,
// forwarding priority, register-0 guard and store-data forwarding.
module tb_ex_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        MEMRegWrite;
    logic [31:0] MEMData;
    logic [4:0]  MEMRd;
    logic        WBRegWrite;
    logic [31:0] WBData;
    logic [4:0]  WBRd;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic [31:0] SignExtend;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic        EXRegWrite;
    logic        EXMemRead;
    logic        EXMemWrite;
    logic [4:0]  EXRd;
    logic [31:0] EXData;
    logic [31:0] EXALUData;

    int vectors = 0;
    int miscompares = 0;

    ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .MEMRegWrite(MEMRegWrite), .MEMData(MEMData), .MEMRd(MEMRd),
        .WBRegWrite(WBRegWrite), .WBData(WBData), .WBRd(WBRd),
        .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .DataA(DataA), .DataB(DataB), .SignExtend(SignExtend),
        .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead), .EXMemWrite(EXMemWrite),
        .EXRd(EXRd), .EXData(EXData), .EXALUData(EXALUData)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        MEMRegWrite = 0; MEMData = '0; MEMRd = '0;
        WBRegWrite = 0;  WBData = '0;  WBRd = '0;
        ALUSrc = 0; ALUControl = 3'b000;
        MemRead = 0; MemWrite = 0; RegWrite = 0;
        DataA = '0; DataB = '0; SignExtend = '0;
        Rs = '0; Rt = '0; Rd = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {29'd0, EXRegWrite, EXMemRead, EXMemWrite}, 32'd0);
        check({tag, "_rd"}, {27'd0, EXRd}, 32'd0);
        check({tag, "_data"}, EXData, 32'd0);
        check({tag, "_alu"}, EXALUData, 32'd0);
    endtask

    task automatic alu_vec(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        clear_inputs();
        ALUControl = op; DataA = a; DataB = b; Rs = 5'd1; Rt = 5'd2;
        tick();
        check(tag, EXALUData, exp);
    endtask

    initial begin
        clear_inputs();
        Rst_n = 1'b0;
        #2;
        check_all_zero("reset");

        // Held in reset across a clock edge with live inputs.
        DataA = 32'd9; DataB = 32'd9; ALUControl = 3'b010; RegWrite = 1; Rd = 5'd3;
        tick();
        check_all_zero("reset_hold");
        Rst_n = 1'b1;

        // ALU sweep
        alu_vec("and",  3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
        alu_vec("or",   3'b001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0);
        alu_vec("add",  3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00E100E0);
        alu_vec("xor",  3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00);
        alu_vec("nor",  3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F);
        alu_vec("sub",  3'b110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hE100E100);
        alu_vec("slt_neg",  3'b111, 32'hFFFFFFFF, 32'h00000001, 32'd1);
        alu_vec("slt_pos",  3'b111, 32'h00000001, 32'hFFFFFFFF, 32'd0);
        alu_vec("sltu_big", 3'b101, 32'hFFFFFFFF, 32'h00000001, 32'd0);
        alu_vec("sltu_sml", 3'b101, 32'h00000001, 32'hFFFFFFFF, 32'd1);
        alu_vec("sub_wrap", 3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF);
        check("sweep_storedata", EXData, 32'h00000001);

        // Immediate path with store
        clear_inputs();
        ALUSrc = 1; DataA = 32'h100; SignExtend = 32'hFFFFFFFC; ALUControl = 3'b010;
        MemWrite = 1; DataB = 32'hAB; Rs = 5'd1; Rt = 5'd2; Rd = 5'd9;
        tick();
        check("imm_alu", EXALUData, 32'h000000FC);
        check("imm_data", EXData, 32'h000000AB);
        check("imm_ctl", {29'd0, EXRegWrite, EXMemRead, EXMemWrite}, 32'b001);
        check("imm_rd", {27'd0, EXRd}, 32'd9);

        // Load: control fields pass through
        clear_inputs();
        MemRead = 1; RegWrite = 1; Rd = 5'd17;
        tick();
        check("load_ctl", {29'd0, EXRegWrite, EXMemRead, EXMemWrite}, 32'b110);
        check("load_rd", {27'd0, EXRd}, 32'd17);

        // Forwarding priority
        clear_inputs();
        Rs = 5'd7; Rt = 5'd7; ALUControl = 3'b010;
        MEMRegWrite = 1; MEMRd = 5'd7; MEMData = 32'd10;
        WBRegWrite = 1;  WBRd = 5'd7;  WBData = 32'd20;
        tick();
        check("fwd_mem_prio", EXALUData, 32'd20);
        MEMRegWrite = 0;
        tick();
        check("fwd_wb", EXALUData, 32'd40);
        WBRegWrite = 0; DataA = 32'd1; DataB = 32'd1;
        tick();
        check("fwd_none", EXALUData, 32'd2);

        // Split sources: A from MEM, B from WB
        clear_inputs();
        Rs = 5'd2; Rt = 5'd3; ALUControl = 3'b110;
        MEMRegWrite = 1; MEMRd = 5'd2; MEMData = 32'd100;
        WBRegWrite = 1;  WBRd = 5'd3;  WBData = 32'd5;
        DataA = 32'd77; DataB = 32'd66;
        tick();
        check("fwd_split", EXALUData, 32'd95);
        check("fwd_split_data", EXData, 32'd5);

        // Register-0 guard, MEM and WB
        clear_inputs();
        ALUControl = 3'b001; MEMRegWrite = 1; MEMRd = 5'd0; MEMData = 32'd99;
        tick();
        check("r0_mem", EXALUData, 32'd0);
        MEMRegWrite = 0; WBRegWrite = 1; WBRd = 5'd0; WBData = 32'd55;
        tick();
        check("r0_wb", EXALUData, 32'd0);

        // Store-data forwarding
        clear_inputs();
        MemWrite = 1; ALUSrc = 1; Rt = 5'd3; Rs = 5'd4; DataA = 32'h1000;
        SignExtend = 32'h8; ALUControl = 3'b010; DataB = 32'h11;
        MEMRegWrite = 1; MEMRd = 5'd3; MEMData = 32'h55;
        tick();
        check("st_fwd_data", EXData, 32'h55);
        check("st_fwd_addr", EXALUData, 32'h1008);

        // Rd=0 write passes through unchanged
        clear_inputs();
        RegWrite = 1; Rd = 5'd0; ALUControl = 3'b010; DataA = 32'd3; DataB = 32'd4;
        tick();
        check("rd0_ctl", {31'd0, EXRegWrite}, 32'd1);
        check("rd0_alu", EXALUData, 32'd7);

        // Bubble propagates as zeros
        clear_inputs();
        tick();
        check_all_zero("bubble");

        // Mid-run asynchronous reset
        DataA = 32'd6; DataB = 32'd6; ALUControl = 3'b010; RegWrite = 1; Rd = 5'd5; MemWrite = 1;
        tick();
        check("pre_reset_alu", EXALUData, 32'd12);
        Rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        Rst_n = 1'b1;
        clear_inputs();
        DataA = 32'd5; DataB = 32'd3; ALUControl = 3'b010; RegWrite = 1; Rd = 5'd4;
        Rs = 5'd1; Rt = 5'd2;
        tick();
        check("post_reset_alu", EXALUData, 32'd8);
        check("post_reset_rw", {31'd0, EXRegWrite}, 32'd1);
        check("post_reset_rd", {27'd0, EXRd}, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
